// File: rtl/seq_div_32_pkg.sv
// rtl/seq_div_32_pkg.sv - shared constants, state encoding and sign helpers for seq_div_32
//
// Purpose : widths, FSM state type and two's-complement helpers used by
//           the divider top and its trial-subtraction adder.
// Ports   : none (package).
package seq_div_32_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int DATA_INDEX_LIMIT = DATA_WIDTH - 1;
  localparam int CNT_WIDTH        = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [DATA_INDEX_LIMIT:0] negate(input logic [DATA_INDEX_LIMIT:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of an operand: only negative values in signed mode are flipped.
  // 0x80000000 maps onto itself, which the unsigned datapath reads as 2^31.
  function automatic logic [DATA_INDEX_LIMIT:0] magnitude(input logic [DATA_INDEX_LIMIT:0] v,
                                                          input logic                    is_signed);
    return (is_signed && v[DATA_INDEX_LIMIT]) ? negate(v) : v;
  endfunction

endpackage

// File: rtl/seq_div_32_rc_add_sub.sv
// rtl/seq_div_32_rc_add_sub.sv - 32-bit ripple-carry adder/subtractor (RC_ADD_SUB_32)
//
// Purpose : Y = A + B (SnA=0) or Y = A - B (SnA=1), ripple carry.
// Ports   : A, B  in  32  operands
//           SnA   in  1   1 = subtract, 0 = add
//           Y     out 32  result
//           CO    out 1   carry out; for subtraction 1 means no borrow (A >= B)
module rc_add_sub_32
  import seq_div_32_pkg::*;
(
  input  logic [DATA_INDEX_LIMIT:0] A,
  input  logic [DATA_INDEX_LIMIT:0] B,
  input  logic                      SnA,
  output logic [DATA_INDEX_LIMIT:0] Y,
  output logic                      CO
);

  logic [DATA_INDEX_LIMIT:0] b_eff;

  assign b_eff = B ^ {DATA_WIDTH{SnA}};

  // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
  always_comb begin
    logic c;
    c = SnA;
    Y = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      Y[i] = A[i] ^ b_eff[i] ^ c;
      c    = (A[i] & b_eff[i]) | (c & (A[i] ^ b_eff[i]));
    end
    CO = c;
  end

endmodule

// File: rtl/seq_div_32.sv
// rtl/seq_div_32.sv - multi-cycle restoring 32-bit divider, signed or unsigned per operation
//
// Purpose : one quotient bit per cycle using a single rc_add_sub_32 for the
//           trial subtraction; fixed 34-cycle latency, 2 cycles on divide-by-zero.
// Ports   : CLK        in  1   clock, rising edge
//           RST        in  1   synchronous active-low reset
//           START      in  1   request, sampled only in IDLE
//           SIGNED     in  1   1 = two's-complement operands, sampled with START
//           DIVIDEND   in  32  numerator, sampled with START
//           DIVISOR    in  32  denominator, sampled with START
//           QUOTIENT   out 32  result, valid from DONE until the next accepted START completes
//           REMAINDER  out 32  result, sign follows dividend
//           BUSY       out 1   high in CALC and FIX
//           DONE       out 1   one-cycle pulse when results become valid
//           DZ         out 1   divide-by-zero flag, held with results
module seq_div_32
  import seq_div_32_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic                      SIGNED,
  input  logic [DATA_INDEX_LIMIT:0] DIVIDEND,
  input  logic [DATA_INDEX_LIMIT:0] DIVISOR,
  output logic [DATA_INDEX_LIMIT:0] QUOTIENT,
  output logic [DATA_INDEX_LIMIT:0] REMAINDER,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      DZ
);

  state_t                    state;
  state_t                    state_next;

  logic [CNT_WIDTH-1:0]      cnt;
  logic [DATA_INDEX_LIMIT:0] rem;
  logic [DATA_INDEX_LIMIT:0] quo;
  logic [DATA_INDEX_LIMIT:0] dvsr_mag;
  logic [DATA_INDEX_LIMIT:0] dvdn_raw;
  logic                      q_neg;
  logic                      r_neg;
  logic                      dz_path;

  logic [DATA_INDEX_LIMIT:0] quotient_r;
  logic [DATA_INDEX_LIMIT:0] remainder_r;
  logic                      dz_r;

  logic [DATA_INDEX_LIMIT:0] shifted;
  logic [DATA_INDEX_LIMIT:0] sub_y;
  logic                      sub_co;
  logic                      accept;

  // Low 32 bits of the 33-bit shifted remainder; the 33rd bit is rem[31].
  assign shifted = {rem[DATA_INDEX_LIMIT-1:0], quo[DATA_INDEX_LIMIT]};

  rc_add_sub_32 u_trial_sub (
    .A   (shifted),
    .B   (dvsr_mag),
    .SnA (1'b1),
    .Y   (sub_y),
    .CO  (sub_co)
  );

  // If the bit shifted out of rem is set, the 33-bit value already exceeds
  // any 32-bit divisor, so the subtraction fits even though CO shows a borrow.
  assign accept = rem[DATA_INDEX_LIMIT] | sub_co;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (START) begin
          state_next = (DIVISOR == '0) ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt == '0) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvsr_mag    <= '0;
      dvdn_raw    <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz_path     <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dz_r        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            dvdn_raw <= DIVIDEND;
            dvsr_mag <= magnitude(DIVISOR, SIGNED);
            quo      <= magnitude(DIVIDEND, SIGNED);
            rem      <= '0;
            cnt      <= CNT_WIDTH'(DATA_INDEX_LIMIT);
            // Sign corrections are pre-gated with SIGNED so FIX needs no mode bit.
            q_neg    <= SIGNED & (DIVIDEND[DATA_INDEX_LIMIT] ^ DIVISOR[DATA_INDEX_LIMIT]);
            r_neg    <= SIGNED & DIVIDEND[DATA_INDEX_LIMIT];
            dz_path  <= (DIVISOR == '0);
          end
        end
        ST_CALC: begin
          rem <= accept ? sub_y : shifted;
          quo <= {quo[DATA_INDEX_LIMIT-1:0], accept};
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_FIX: begin
          if (dz_path) begin
            quotient_r  <= '1;
            remainder_r <= dvdn_raw;
            dz_r        <= 1'b1;
          end else begin
            quotient_r  <= q_neg ? negate(quo) : quo;
            remainder_r <= r_neg ? negate(rem) : rem;
            dz_r        <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign QUOTIENT  = quotient_r;
  assign REMAINDER = remainder_r;
  assign DZ        = dz_r;
  assign BUSY      = (state == ST_CALC) || (state == ST_FIX);
  assign DONE      = (state == ST_DONE);

endmodule

// File: tb/tb_seq_div_32.sv
// tb/tb_seq_div_32.sv - self-checking testbench for seq_div_32
module tb_seq_div_32;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        SIGNED;
  logic [31:0] DIVIDEND;
  logic [31:0] DIVISOR;
  logic [31:0] QUOTIENT;
  logic [31:0] REMAINDER;
  logic        BUSY;
  logic        DONE;
  logic        DZ;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  seq_div_32 dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .SIGNED    (SIGNED),
    .DIVIDEND  (DIVIDEND),
    .DIVISOR   (DIVISOR),
    .QUOTIENT  (QUOTIENT),
    .REMAINDER (REMAINDER),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .DZ        (DZ)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain integer division on 64-bit values; truncation toward zero
  // gives the remainder the dividend's sign, and the 0x80000000/-1 case wraps
  // naturally when the 64-bit quotient is cut to 32 bits.
  function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint x;
    longint y;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else begin
      if (sgn) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
      end else begin
        x = longint'({32'd0, a});
        y = longint'({32'd0, b});
      end
      q  = 32'(x / y);
      r  = 32'(x % y);
      dz = 1'b0;
    end
  endfunction

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz,
                        input bit repulse);
    int cycles;
    int busy_cnt;
    int exp_lat;
    exp_lat  = edz ? 2 : 34;
    SIGNED   = sgn;
    DIVIDEND = a;
    DIVISOR  = b;
    START    = 1'b1;
    @(posedge CLK);
    #1;
    START    = 1'b0;
    cycles   = 1;
    busy_cnt = 0;
    while (!DONE && cycles < 100) begin
      if (BUSY) busy_cnt++;
      if (repulse && cycles == 3) begin
        START    = 1'b1;
        SIGNED   = ~sgn;
        DIVIDEND = $urandom;
        DIVISOR  = $urandom;
      end else begin
        START = 1'b0;
      end
      @(posedge CLK);
      #1;
      cycles++;
    end
    START = 1'b0;
    check({tag, " latency"}, 32'(cycles), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    check({tag, " busy_in_done"}, 32'(BUSY), 32'd0);
    check({tag, " quotient"}, QUOTIENT, eq);
    check({tag, " remainder"}, REMAINDER, er);
    check({tag, " dz"}, 32'(DZ), 32'(edz));
    @(posedge CLK);
    #1;
    check({tag, " done_pulse"}, 32'(DONE), 32'd0);
    check({tag, " quotient_held"}, QUOTIENT, eq);
  endtask

  initial begin
    logic [31:0] mq;
    logic [31:0] mr;
    logic        mdz;
    logic        rs;
    logic [31:0] ra;
    logic [31:0] rb;
    int          done_seen;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0};
    vecs[2] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[3] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[4] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[5] = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[6] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[7] = '{1'b0, 32'd0,          32'd1,          32'd0,          32'd0,          1'b0};
    vecs[8] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};

    RST      = 1'b0;
    START    = 1'b0;
    SIGNED   = 1'b0;
    DIVIDEND = '0;
    DIVISOR  = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset quotient", QUOTIENT, 32'd0);
    check("reset remainder", REMAINDER, 32'd0);
    check("reset dz", 32'(DZ), 32'd0);
    check("reset busy", 32'(BUSY), 32'd0);
    check("reset done", 32'(DONE), 32'd0);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
             vecs[i].q, vecs[i].r, vecs[i].dz, 1'b0);
    end

    // Reset in the middle of CALC, with a START re-pulse that must be ignored.
    SIGNED   = 1'b0;
    DIVIDEND = 32'd1000;
    DIVISOR  = 32'd3;
    START    = 1'b1;
    @(posedge CLK);
    #1;
    for (int k = 1; k < 10; k++) begin
      START = (k == 5);
      if (k == 5) begin
        DIVIDEND = 32'd77;
        DIVISOR  = 32'd0;
      end
      @(posedge CLK);
      #1;
    end
    START = 1'b0;
    check("midop busy_before_reset", 32'(BUSY), 32'd1);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    check("midop reset quotient", QUOTIENT, 32'd0);
    check("midop reset remainder", REMAINDER, 32'd0);
    check("midop reset dz", 32'(DZ), 32'd0);
    check("midop reset busy", 32'(BUSY), 32'd0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (DONE || BUSY) done_seen++;
      @(posedge CLK);
      #1;
    end
    check("midop no_done_after_reset", 32'(done_seen), 32'd0);
    run_op("after_reset", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);

    // Randomized operations against the reference model, some with a mid-op START.
    for (int i = 0; i < 30; i++) begin
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'($urandom_range(0, 50));
        default: ra = $urandom;
      endcase
      model(rs, ra, rb, mq, mr, mdz);
      run_op($sformatf("rand%0d", i), rs, ra, rb, mq, mr, mdz, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
